// File: rtl/rv32v_element_sequencer.sv
// rv32v_element_sequencer: turns one vector op (vl/vstart/sew/lmul) into a stream of
// NUM_LANES-wide element beats carrying element index, register-group offset, byte
// offset and active flag. Single op in flight, valid/ready on the beat side.
// Optional feature macro RV32V_SEQ_MASK_EN: adds vm/v0_mask ports and masks the active flag.
module rv32v_element_sequencer #(
  parameter int NUM_LANES = 2,
  parameter int VLEN      = 128,
  parameter int VL_W      = 8
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  start,
  output logic                                  start_ready,
  input  logic [VL_W-1:0]                       vl,
  input  logic [VL_W-1:0]                       vstart,
  input  logic [2:0]                            sew,
  input  logic [2:0]                            lmul,
  input  logic                                  flush,
`ifdef RV32V_SEQ_MASK_EN
  input  logic                                  vm,
  input  logic [VLEN-1:0]                       v0_mask,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_LANES*VL_W-1:0]             out_elem,
  output logic [NUM_LANES*3-1:0]                out_reg_off,
  output logic [NUM_LANES*$clog2(VLEN/8)-1:0]   out_byte_off,
  output logic [NUM_LANES-1:0]                  out_active,
  output logic                                  out_last,
  output logic                                  done,
  output logic                                  vl_err
);

  localparam int BOFF_W = $clog2(VLEN/8);  // byte offset bits within one register
  localparam int B_W    = VL_W + 1;        // one spare bit so base+NUM_LANES never wraps
  localparam int BA_W   = B_W + 2;         // byte address after a shift by up to SEW32

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [B_W-1:0]   base_q, end_q;
  logic [1:0]       sew_q;
  logic             vl_err_q;
  logic             launch, advance;

  logic [15:0]      vlmax_sew, vlmax;
  logic             sel_illegal, vl_over;
  logic [B_W-1:0]   end_calc;

`ifdef RV32V_SEQ_MASK_EN
  localparam int IDX_W = $clog2(VLEN);
  logic             vm_q;
  logic [VLEN-1:0]  v0_mask_q;
`endif

  // Decode the incoming op: VLMAX from sew/lmul, legality, and the clipped end index.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    vlmax_sew = 16'(VLEN) >> (4'd3 + {1'b0, sew});
    vlmax     = '0;
    unique case (lmul)
      3'd0:    vlmax = vlmax_sew;
      3'd1:    vlmax = vlmax_sew << 1;
      3'd2:    vlmax = vlmax_sew << 2;
      3'd3:    vlmax = vlmax_sew << 3;
      3'd5:    vlmax = vlmax_sew >> 3;
      3'd6:    vlmax = vlmax_sew >> 2;
      3'd7:    vlmax = vlmax_sew >> 1;
      default: vlmax = '0;
    endcase
    sel_illegal = (sew > 3'd2) || (lmul == 3'd4);
    vl_over     = 16'(vl) > vlmax;
    if (sel_illegal)  end_calc = '0;
    else if (vl_over) end_calc = B_W'(vlmax);
    else              end_calc = B_W'(vl);
  end

  // FSM next state and control outputs; flush overrides start and the beat handshake.
  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    advance     = 1'b0;
    start_ready = (state_q == S_IDLE);
    out_valid   = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          launch  = 1'b1;
          state_d = (B_W'(vstart) < end_calc) ? S_RUN : S_DONE;
        end
        S_RUN: if (out_ready) begin
          advance = 1'b1;
          if (out_last) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register plus the per-op context latched at launch.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    if (RST) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      end_q    <= '0;
      sew_q    <= '0;
      vl_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        base_q   <= B_W'(vstart);
        end_q    <= end_calc;
        sew_q    <= sew[1:0];
        vl_err_q <= sel_illegal || vl_over;
      end else if (advance) begin
        base_q <= base_q + B_W'(NUM_LANES);
      end
    end
  end

`ifdef RV32V_SEQ_MASK_EN
  // Mask context captured at launch.
  always_ff @(posedge CLK) begin
    // NOTE: the wide mask register has no reset; it is always loaded at launch before any
    // beat reads it, so resetting it would only add reset fan-out.
    if (launch) begin
      vm_q      <= vm;
      v0_mask_q <= v0_mask;
    end
  end
`endif

  assign vl_err = vl_err_q;

  // Per-lane beat contents, derived from the current base; inactive lanes carry zero offsets.
  always_comb begin
    logic [B_W-1:0]  lane_elem;
    logic [BA_W-1:0] lane_baddr;
    logic            lane_act;
    logic            running;
    running      = (state_q == S_RUN);
    out_elem     = '0;
    out_reg_off  = '0;
    out_byte_off = '0;
    out_active   = '0;
    lane_elem    = '0;
    lane_baddr   = '0;
    lane_act     = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_elem  = base_q + B_W'(i);
      lane_baddr = BA_W'(lane_elem) << sew_q;
`ifdef RV32V_SEQ_MASK_EN
      lane_act   = running && (lane_elem < end_q) && (vm_q || v0_mask_q[IDX_W'(lane_elem)]);
`else
      lane_act   = running && (lane_elem < end_q);
`endif
      if (running) out_elem[i*VL_W +: VL_W] = VL_W'(lane_elem);
      if (lane_act) begin
        out_active[i]                     = 1'b1;
        out_reg_off[i*3 +: 3]             = 3'(lane_baddr >> BOFF_W);
        out_byte_off[i*BOFF_W +: BOFF_W]  = BOFF_W'(lane_baddr);
      end
    end
    out_last = running && ((base_q + B_W'(NUM_LANES)) >= end_q);
  end

endmodule
